// File: rtl/lc4_issue_scheduler_pkg.sv
// Shared widths and FSM encodings for the lc4 issue scheduler slice.
// Also holds the age helper used by the picker.
package lc4_issue_scheduler_pkg;
    localparam int N_ENT     = 4;
    localparam int ROB_IDX_W = 2;
    localparam int PREG_W    = 4;
    localparam int N_PREG    = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    // Entry age relative to the ROB head; wraps naturally in ROB_IDX_W bits.
    function automatic logic [ROB_IDX_W-1:0] entry_at_age(input logic [ROB_IDX_W-1:0] head,
                                                          input logic [ROB_IDX_W-1:0] age);
        return head + age;
    endfunction
endpackage

// File: rtl/lc4_issue_scheduler_age_picker.sv
// Combinational oldest-first picker over the 4 ROB entries, with an optional
// single-entry mask so an entry being handed off is not picked twice.
module lc4_age_picker
    import lc4_issue_scheduler_pkg::*;
(
    input  logic [N_ENT-1:0]     elig,
    input  logic [ROB_IDX_W-1:0] head,
    input  logic                 mask_en,
    input  logic [ROB_IDX_W-1:0] mask_idx,
    output logic                 found,
    output logic [ROB_IDX_W-1:0] idx
);
    logic [ROB_IDX_W-1:0] cand;

    // Walk from youngest to oldest so the last hit is the oldest eligible entry.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int a = N_ENT - 1; a >= 0; a--) begin
            cand = entry_at_age(head, ROB_IDX_W'(a));
            if (elig[cand] && !(mask_en && (cand == mask_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/lc4_issue_scheduler.sv
// Issue controller for the 4-entry ROB: scoreboard of physical-register readiness,
// oldest-ready pick, and a valid/ready offer to the single execute unit.
module lc4_issue_scheduler
    import lc4_issue_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        gwe,
    input  logic        flush,
    input  logic [1:0]  rob_head,
    input  logic [3:0]  iq_valid,
    input  logic [3:0]  iq_issue,
    input  logic [3:0]  iq0_pr1sel,
    input  logic [3:0]  iq1_pr1sel,
    input  logic [3:0]  iq2_pr1sel,
    input  logic [3:0]  iq3_pr1sel,
    input  logic [3:0]  iq0_pr2sel,
    input  logic [3:0]  iq1_pr2sel,
    input  logic [3:0]  iq2_pr2sel,
    input  logic [3:0]  iq3_pr2sel,
    input  logic [3:0]  iq_uses_r1,
    input  logic [3:0]  iq_uses_r2,
    input  logic        alloc_en,
    input  logic [3:0]  alloc_prd,
    input  logic        wb_en,
    input  logic [3:0]  wb_prd,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [1:0]  ex_index,
    output logic        rob_issue,
    output logic [1:0]  is_index_out,
    output logic [15:0] sb_ready
);
    // Handshake: a transfer happens on a cycle where ex_valid & ex_ready are both
    // high and no flush is active; ex_valid/ex_index hold steady until then.

    logic [PREG_W-1:0]    pr1sel [N_ENT];
    logic [PREG_W-1:0]    pr2sel [N_ENT];
    logic [N_ENT-1:0]     elig;
    logic [N_PREG-1:0]    sb_next;
    logic [0:0]           state;
    logic [0:0]           state_next;
    logic                 ex_valid_next;
    logic [ROB_IDX_W-1:0] ex_index_next;
    logic                 pick_found;
    logic [ROB_IDX_W-1:0] pick_idx;
    logic                 offer_live;

    assign pr1sel[0] = iq0_pr1sel;
    assign pr1sel[1] = iq1_pr1sel;
    assign pr1sel[2] = iq2_pr1sel;
    assign pr1sel[3] = iq3_pr1sel;
    assign pr2sel[0] = iq0_pr2sel;
    assign pr2sel[1] = iq1_pr2sel;
    assign pr2sel[2] = iq2_pr2sel;
    assign pr2sel[3] = iq3_pr2sel;

    // Registered scoreboard only: a consumer wakes the cycle after its writeback.
    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            elig[i] = iq_valid[i] && !iq_issue[i]
                   && (!iq_uses_r1[i] || sb_ready[pr1sel[i]])
                   && (!iq_uses_r2[i] || sb_ready[pr2sel[i]]);
        end
    end

    // Clear is applied after set so an alloc of the same preg wins.
    always_comb begin
        sb_next = sb_ready;
        if (flush) begin
            sb_next = '1;
        end else begin
            if (wb_en)    sb_next[wb_prd]    = 1'b1;
            if (alloc_en) sb_next[alloc_prd] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      sb_ready <= '1;
        else if (gwe) sb_ready <= sb_next;
    end

    lc4_age_picker u_picker (
        .elig     (elig),
        .head     (rob_head),
        .mask_en  (state == ST_OFFER),
        .mask_idx (ex_index),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // An offer whose ROB entry vanished never hands off.
    assign offer_live   = iq_valid[ex_index];
    assign rob_issue    = ex_valid && ex_ready && !flush && offer_live;
    assign is_index_out = ex_index;

    always_comb begin
        state_next    = state;
        ex_valid_next = ex_valid;
        ex_index_next = ex_index;
        if (flush) begin
            state_next    = ST_IDLE;
            ex_valid_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_next    = ST_OFFER;
                        ex_valid_next = 1'b1;
                        ex_index_next = pick_idx;
                    end
                end
                ST_OFFER: begin
                    if (!offer_live) begin
                        state_next    = ST_IDLE;
                        ex_valid_next = 1'b0;
                    end else if (ex_ready) begin
                        if (pick_found) begin
                            ex_index_next = pick_idx;
                        end else begin
                            state_next    = ST_IDLE;
                            ex_valid_next = 1'b0;
                        end
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    ex_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ex_valid <= 1'b0;
            ex_index <= '0;
        end else if (gwe) begin
            state    <= state_next;
            ex_valid <= ex_valid_next;
            ex_index <= ex_index_next;
        end
    end
endmodule

// File: tb/tb_lc4_issue_scheduler.sv
// Directed bench for lc4_issue_scheduler with a tiny ROB model that sets
// iq_issue for an entry after it is handed off.
module tb_lc4_issue_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        gwe;
    logic        flush;
    logic [1:0]  rob_head;
    logic [3:0]  iq_valid;
    logic [3:0]  iq_issue;
    logic [3:0]  iq0_pr1sel, iq1_pr1sel, iq2_pr1sel, iq3_pr1sel;
    logic [3:0]  iq0_pr2sel, iq1_pr2sel, iq2_pr2sel, iq3_pr2sel;
    logic [3:0]  iq_uses_r1;
    logic [3:0]  iq_uses_r2;
    logic        alloc_en;
    logic [3:0]  alloc_prd;
    logic        wb_en;
    logic [3:0]  wb_prd;
    logic        ex_ready;
    logic        ex_valid;
    logic [1:0]  ex_index;
    logic        rob_issue;
    logic [1:0]  is_index_out;
    logic [15:0] sb_ready;

    int n_checks = 0;
    int n_errors = 0;

    lc4_issue_scheduler dut (
        .clk(clk), .rst(rst), .gwe(gwe), .flush(flush), .rob_head(rob_head),
        .iq_valid(iq_valid), .iq_issue(iq_issue),
        .iq0_pr1sel(iq0_pr1sel), .iq1_pr1sel(iq1_pr1sel),
        .iq2_pr1sel(iq2_pr1sel), .iq3_pr1sel(iq3_pr1sel),
        .iq0_pr2sel(iq0_pr2sel), .iq1_pr2sel(iq1_pr2sel),
        .iq2_pr2sel(iq2_pr2sel), .iq3_pr2sel(iq3_pr2sel),
        .iq_uses_r1(iq_uses_r1), .iq_uses_r2(iq_uses_r2),
        .alloc_en(alloc_en), .alloc_prd(alloc_prd), .wb_en(wb_en), .wb_prd(wb_prd),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_index(ex_index),
        .rob_issue(rob_issue), .is_index_out(is_index_out), .sb_ready(sb_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; the ROB model marks a handed-off entry as issued after the edge.
    task automatic step();
        logic       hs;
        logic [1:0] hi;
        hs = rob_issue;
        hi = is_index_out;
        @(posedge clk);
        #1;
        if (hs) iq_issue[hi] = 1'b1;
    endtask

    task automatic clear_rob();
        iq_valid   = '0;
        iq_issue   = '0;
        iq_uses_r1 = '0;
        iq_uses_r2 = '0;
        ex_ready   = 1'b0;
        rob_head   = '0;
    endtask

    initial begin
        rst = 1'b1; gwe = 1'b1; flush = 1'b0;
        alloc_en = 1'b0; alloc_prd = '0; wb_en = 1'b0; wb_prd = '0;
        iq0_pr1sel = 4'd0; iq1_pr1sel = 4'd0; iq2_pr1sel = 4'd0; iq3_pr1sel = 4'd0;
        iq0_pr2sel = 4'd0; iq1_pr2sel = 4'd0; iq2_pr2sel = 4'd0; iq3_pr2sel = 4'd0;
        clear_rob();
        step(); step();
        check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_eq("rst_ex_index", 32'(ex_index), 32'd0);
        check_eq("rst_sb_ready", 32'(sb_ready), 32'hFFFF);
        rst = 1'b0;
        step();

        // Empty ROB, with ex_ready high and nothing offered
        ex_ready = 1'b1;
        step(); step();
        check_eq("empty_idle", 32'(ex_valid), 32'd0);
        check_eq("ready_ignored", 32'(rob_issue), 32'd0);
        ex_ready = 1'b0;

        // gwe low freezes the scoreboard
        gwe = 1'b0; alloc_en = 1'b1; alloc_prd = 4'd4;
        step();
        check_eq("gwe_hold", 32'(sb_ready), 32'hFFFF);
        gwe = 1'b1;

        // Alloc and writeback of the same preg: clear wins
        alloc_prd = 4'd9; wb_en = 1'b1; wb_prd = 4'd9;
        step();
        check_eq("clear_wins", 32'(sb_ready), 32'hFDFF);
        alloc_en = 1'b0;
        step();
        check_eq("wb_sets", 32'(sb_ready), 32'hFFFF);
        wb_en = 1'b0;

        // Wakeup: entry 1 waits on preg 5
        alloc_en = 1'b1; alloc_prd = 4'd5;
        step();
        alloc_en = 1'b0;
        iq_valid = 4'b0010; iq1_pr1sel = 4'd5; iq_uses_r1 = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("blocked_r1", 32'(ex_valid), 32'd0);
        end
        wb_en = 1'b1; wb_prd = 4'd5;
        step();
        wb_en = 1'b0;
        check_eq("wake_t1_valid", 32'(ex_valid), 32'd0);
        step();
        check_eq("wake_t2_valid", 32'(ex_valid), 32'd1);
        check_eq("wake_t2_index", 32'(ex_index), 32'd1);

        // Offered entry disappears without flush: offer dropped
        iq_valid = 4'b0000;
        #1;
        check_eq("drop_no_issue", 32'(rob_issue), 32'd0);
        step();
        check_eq("drop_valid", 32'(ex_valid), 32'd0);
        clear_rob();
        step();

        // Stall while offering index 2, then a single handoff
        iq_valid = 4'b0100;
        step();
        check_eq("stall_offer", 32'(ex_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("stall_index", 32'(ex_index), 32'd2);
            check_eq("stall_no_issue", 32'(rob_issue), 32'd0);
        end
        ex_ready = 1'b1;
        #1;
        check_eq("stall_hs_issue", 32'(rob_issue), 32'd1);
        check_eq("stall_hs_index", 32'(is_index_out), 32'd2);
        step();
        check_eq("stall_single_pulse", 32'(rob_issue), 32'd0);
        check_eq("stall_back_idle", 32'(ex_valid), 32'd0);
        clear_rob();
        step();

        // Back-to-back issue of entries 0 then 1
        iq_valid = 4'b0011; ex_ready = 1'b1;
        step();
        check_eq("b2b_issue0", 32'(rob_issue), 32'd1);
        check_eq("b2b_index0", 32'(is_index_out), 32'd0);
        step();
        check_eq("b2b_issue1", 32'(rob_issue), 32'd1);
        check_eq("b2b_index1", 32'(is_index_out), 32'd1);
        step();
        check_eq("b2b_done", 32'(ex_valid), 32'd0);
        step();
        check_eq("b2b_no_reoffer", 32'(ex_valid), 32'd0);
        clear_rob();
        step();

        // Wrap order with head=2: 3, 0, 1
        rob_head = 2'd2; iq_valid = 4'b1011; ex_ready = 1'b1;
        step();
        check_eq("wrap_first", 32'(is_index_out), 32'd3);
        check_eq("wrap_first_issue", 32'(rob_issue), 32'd1);
        step();
        check_eq("wrap_second", 32'(is_index_out), 32'd0);
        step();
        check_eq("wrap_third", 32'(is_index_out), 32'd1);
        step();
        check_eq("wrap_done", 32'(ex_valid), 32'd0);
        clear_rob();
        step();

        // Flush during offer, alongside an alloc of preg 7
        alloc_en = 1'b1; alloc_prd = 4'd12;
        step();
        alloc_en = 1'b0;
        check_eq("pre_flush_sb", 32'(sb_ready), 32'hEFFF);
        iq_valid = 4'b0100;
        step();
        check_eq("pre_flush_offer", 32'(ex_valid), 32'd1);
        flush = 1'b1; alloc_en = 1'b1; alloc_prd = 4'd7; ex_ready = 1'b1;
        #1;
        check_eq("flush_no_issue", 32'(rob_issue), 32'd0);
        step();
        flush = 1'b0; alloc_en = 1'b0;
        clear_rob();
        check_eq("flush_valid", 32'(ex_valid), 32'd0);
        check_eq("flush_index_kept", 32'(ex_index), 32'd2);
        check_eq("flush_sb_all", 32'(sb_ready), 32'hFFFF);
        step();

        // Asynchronous reset in the middle of an offer
        iq_valid = 4'b0001; alloc_en = 1'b1; alloc_prd = 4'd3;
        step();
        alloc_en = 1'b0;
        check_eq("pre_rst_offer", 32'(ex_valid), 32'd1);
        check_eq("pre_rst_sb", 32'(sb_ready), 32'hFFF7);
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 32'(ex_valid), 32'd0);
        check_eq("async_rst_sb", 32'(sb_ready), 32'hFFFF);
        #1 rst = 1'b0;
        step();
        check_eq("post_rst_pick", 32'(ex_valid), 32'd1);
        check_eq("post_rst_index", 32'(ex_index), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
